// File: rtl/conv_pkg.sv
// Shared constants and types for the conv_128_32 input stage.
package conv_pkg;

  localparam int LEN_X = 128;               // x vector length (samples)
  localparam int LEN_F = 32;                // f vector length (taps)
  localparam int DW    = 8;                 // signed sample width

  localparam int XAW = $clog2(LEN_X);       // x memory address width
  localparam int FAW = $clog2(LEN_F);       // f memory address width
  localparam int XCW = $clog2(LEN_X + 1);   // x counter width, holds 0..LEN_X
  localparam int FCW = $clog2(LEN_F + 1);   // f counter width, holds 0..LEN_F

  typedef enum logic {
    LOAD = 1'b0,                            // accepting input
    FULL = 1'b1                             // holding a complete vector pair
  } loader_state_t;

endpackage

// File: rtl/loader_mem.sv
// DEPTH x DW buffer: one write port, one synchronous read port whose
// registered output resets to 0.
module loader_mem #(
  parameter  int DEPTH = 128,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage array write.
  // NOTE: storage has no reset so it maps onto plain RAM; valid data is
  // tracked by the loader counters, not by the array contents.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every register update in a clocked
    // block ordered against other processes reading the same state.
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port, one cycle from address to data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_input_loader.sv
// Input stage of the conv_128_32 engine: collects one x vector and one f
// vector from independent valid/ready streams, then holds them for reading
// until the datapath pulses release. `release` is a reserved word in
// SystemVerilog, so that pulse input is named release_i.
module conv_input_loader
  import conv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,        // asynchronous, active low
  input  logic [DW-1:0]  s_data_in_x,
  input  logic           s_valid_x,
  output logic           s_ready_x,
  input  logic [DW-1:0]  s_data_in_f,
  input  logic           s_valid_f,
  output logic           s_ready_f,
  output logic           loaded,
  input  logic           release_i,
  input  logic [XAW-1:0] rd_addr_x,
  output logic [DW-1:0]  rd_data_x,
  input  logic [FAW-1:0] rd_addr_f,
  output logic [DW-1:0]  rd_data_f
);

  loader_state_t  state_q, state_d;
  logic [XCW-1:0] x_cnt_q, x_cnt_d;
  logic [FCW-1:0] f_cnt_q, f_cnt_d;
  logic           run_q;               // low during reset, high from the first edge after
  logic           x_fire, f_fire;

  assign x_fire = s_valid_x & s_ready_x;
  assign f_fire = s_valid_f & s_ready_f;

  // Readys come only from registered state so no valid->ready path exists;
  // run_q keeps them low until the first edge after reset deasserts.
  assign s_ready_x = run_q && (state_q == LOAD) && (x_cnt_q != XCW'(LEN_X));
  assign s_ready_f = run_q && (state_q == LOAD) && (f_cnt_q != FCW'(LEN_F));
  assign loaded    = (state_q == FULL);

  // Next-state and counter update.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;

    if (x_fire) x_cnt_d = x_cnt_q + XCW'(1);
    if (f_fire) f_cnt_d = f_cnt_q + FCW'(1);

    case (state_q)
      LOAD: begin
        // Completion counts a transfer landing on this same edge.
        if (x_cnt_d == XCW'(LEN_X) && f_cnt_d == FCW'(LEN_F)) state_d = FULL;
      end
      FULL: begin
        if (release_i) begin
          state_d = LOAD;
          x_cnt_d = '0;
          f_cnt_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and counter registers; reset discards any partial load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      x_cnt_q <= '0;
      f_cnt_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      f_cnt_q <= f_cnt_d;
      run_q   <= 1'b1;
    end
  end

  loader_mem #(.DEPTH(LEN_X), .DW(DW)) u_mem_x (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (x_fire),
    .waddr_i (x_cnt_q[XAW-1:0]),
    .wdata_i (s_data_in_x),
    .raddr_i (rd_addr_x),
    .rdata_o (rd_data_x)
  );

  loader_mem #(.DEPTH(LEN_F), .DW(DW)) u_mem_f (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (f_fire),
    .waddr_i (f_cnt_q[FAW-1:0]),
    .wdata_i (s_data_in_f),
    .raddr_i (rd_addr_f),
    .rdata_o (rd_data_f)
  );

endmodule

// File: tb/tb_conv_input_loader.sv
// Directed bench for conv_input_loader: stream loads, FULL hold, release,
// release during LOAD, mid-load reset and read-back of both buffers.
module tb_conv_input_loader;
  import conv_pkg::*;

  localparam int BUDGET = 3000;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  s_data_in_x, s_data_in_f;
  logic           s_valid_x, s_valid_f;
  logic           s_ready_x, s_ready_f;
  logic           loaded;
  logic           release_i;
  logic [XAW-1:0] rd_addr_x;
  logic [FAW-1:0] rd_addr_f;
  logic [DW-1:0]  rd_data_x, rd_data_f;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] exp_x [LEN_X];
  logic [DW-1:0] exp_f [LEN_F];
  int m_xi, m_fi;                     // model transfer counts for the current load

  conv_input_loader dut (
    .clk         (clk),
    .reset       (reset),
    .s_data_in_x (s_data_in_x),
    .s_valid_x   (s_valid_x),
    .s_ready_x   (s_ready_x),
    .s_data_in_f (s_data_in_f),
    .s_valid_f   (s_valid_f),
    .s_ready_f   (s_ready_f),
    .loaded      (loaded),
    .release_i   (release_i),
    .rd_addr_x   (rd_addr_x),
    .rd_data_x   (rd_data_x),
    .rd_addr_f   (rd_addr_f),
    .rd_data_f   (rd_data_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive both streams from exp_x/exp_f until the model counts reach the
  // limits; readys and loaded are compared against the model every cycle.
  task automatic stream(input string tag, input int pv_x, input int pv_f,
                        input bit x_first, input int x_lim, input int f_lim);
    int cyc     = 0;
    int bad_rdy = 0;
    int bad_ld  = 0;
    bit vx, vf;
    while ((m_xi < x_lim || m_fi < f_lim) && cyc < BUDGET) begin
      vx = (m_xi < x_lim) && ($urandom_range(99) < pv_x);
      vf = (m_fi < f_lim) && !(x_first && m_xi < LEN_X) && ($urandom_range(99) < pv_f);
      s_valid_x   = vx;
      s_data_in_x = vx ? exp_x[m_xi] : 'x;
      s_valid_f   = vf;
      s_data_in_f = vf ? exp_f[m_fi] : 'x;
      if (s_ready_x !== (m_xi != LEN_X)) bad_rdy++;
      if (s_ready_f !== (m_fi != LEN_F)) bad_rdy++;
      if (loaded !== 1'b0) bad_ld++;
      step();
      if (vx) m_xi++;
      if (vf) m_fi++;
      cyc++;
    end
    s_valid_x   = 1'b0;
    s_valid_f   = 1'b0;
    s_data_in_x = 'x;
    s_data_in_f = 'x;
    check({tag, "_finished"}, int'(cyc < BUDGET), 1);
    check({tag, "_ready_errs"}, bad_rdy, 0);
    check({tag, "_early_loaded"}, bad_ld, 0);
    if (m_xi == LEN_X && m_fi == LEN_F) begin
      check({tag, "_loaded"}, int'(loaded), 1);
      check({tag, "_rdy_x_low"}, int'(s_ready_x), 0);
      check({tag, "_rdy_f_low"}, int'(s_ready_f), 0);
    end
  endtask

  // Read every address of both buffers with one-cycle latency.
  task automatic read_all(input string tag);
    int errs = 0;
    for (int a = 0; a < LEN_X; a++) begin
      rd_addr_x = XAW'(a);
      rd_addr_f = FAW'(a % LEN_F);
      step();
      if (rd_data_x !== exp_x[a]) errs++;
      if (a < LEN_F && rd_data_f !== exp_f[a]) errs++;
    end
    check(tag, errs, 0);
  endtask

  task automatic pulse_release();
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    m_xi = 0;
    m_fi = 0;
  endtask

  initial begin
    reset       = 1'b0;
    s_valid_x   = 1'b0;
    s_valid_f   = 1'b0;
    s_data_in_x = '0;
    s_data_in_f = '0;
    release_i   = 1'b0;
    rd_addr_x   = '0;
    rd_addr_f   = '0;
    m_xi        = 0;
    m_fi        = 0;

    // Reset state
    step();
    step();
    check("rst_rdy_x", int'(s_ready_x), 0);
    check("rst_rdy_f", int'(s_ready_f), 0);
    check("rst_loaded", int'(loaded), 0);
    check("rst_rd_x", int'(rd_data_x), 0);
    check("rst_rd_f", int'(rd_data_f), 0);
    reset = 1'b1;
    step();
    check("post_rst_rdy_x", int'(s_ready_x), 1);
    check("post_rst_rdy_f", int'(s_ready_f), 1);

    // Continuous streams x = -128..-1, f = -64..-33
    for (int i = 0; i < LEN_X; i++) exp_x[i] = DW'(i - 128);
    for (int i = 0; i < LEN_F; i++) exp_f[i] = DW'(i - 64);
    stream("cont", 100, 100, 1'b0, LEN_X, LEN_F);
    rd_addr_x = XAW'(5);
    rd_addr_f = FAW'(31);
    step();
    check("cont_x5", int'($signed(rd_data_x)), -123);
    check("cont_f31", int'($signed(rd_data_f)), -33);

    // FULL: valids held high with junk data must be ignored
    s_valid_x   = 1'b1;
    s_valid_f   = 1'b1;
    s_data_in_x = 8'h55;
    s_data_in_f = 8'h55;
    begin
      int bad = 0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (s_ready_x !== 1'b0 || s_ready_f !== 1'b0 || loaded !== 1'b1) bad++;
      end
      check("full_hold", bad, 0);
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    read_all("full_frozen");

    // Release: readys back the cycle after the release edge
    pulse_release();
    check("rel_rdy_x", int'(s_ready_x), 1);
    check("rel_rdy_f", int'(s_ready_f), 1);
    check("rel_loaded", int'(loaded), 0);

    // Second pair x = 0..127, f = 0..31
    for (int i = 0; i < LEN_X; i++) exp_x[i] = DW'(i);
    for (int i = 0; i < LEN_F; i++) exp_f[i] = DW'(i);
    stream("second", 100, 100, 1'b0, LEN_X, LEN_F);
    rd_addr_x = XAW'(127);
    rd_addr_f = FAW'(0);
    step();
    check("second_x127", int'($signed(rd_data_x)), 127);
    check("second_f0", int'($signed(rd_data_f)), 0);
    pulse_release();

    // f finishes last: all x first, then f
    for (int i = 0; i < LEN_X; i++) exp_x[i] = DW'(3 * i - 100);
    for (int i = 0; i < LEN_F; i++) exp_f[i] = DW'(7 * i - 5);
    stream("flast", 100, 100, 1'b1, LEN_X, LEN_F);
    read_all("flast_mem");
    pulse_release();

    // Randomized valids, X on data while invalid
    for (int i = 0; i < LEN_X; i++) exp_x[i] = DW'($urandom);
    for (int i = 0; i < LEN_F; i++) exp_f[i] = DW'($urandom);
    stream("rand", 45, 20, 1'b0, LEN_X, LEN_F);
    read_all("rand_mem");
    pulse_release();

    // Release during LOAD after 10 x transfers is ignored
    for (int i = 0; i < LEN_X; i++) exp_x[i] = DW'(LEN_X - 1 - i);
    for (int i = 0; i < LEN_F; i++) exp_f[i] = DW'(2 * i + 1);
    stream("pre_rel", 100, 0, 1'b0, 10, 0);
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    check("load_rel_rdy_x", int'(s_ready_x), 1);
    check("load_rel_loaded", int'(loaded), 0);
    stream("post_rel", 100, 100, 1'b0, LEN_X, LEN_F);
    read_all("post_rel_mem");
    pulse_release();

    // Mid-load reset off a clock edge after 50 x transfers
    for (int i = 0; i < LEN_X; i++) exp_x[i] = DW'(8'hA0);
    for (int i = 0; i < LEN_F; i++) exp_f[i] = DW'(8'h0F);
    stream("pre_rst", 100, 100, 1'b0, 50, 20);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_rdy_x", int'(s_ready_x), 0);
    check("async_rst_rdy_f", int'(s_ready_f), 0);
    check("async_rst_loaded", int'(loaded), 0);
    check("async_rst_rd_x", int'(rd_data_x), 0);
    step();
    reset = 1'b1;
    step();
    m_xi = 0;
    m_fi = 0;
    for (int i = 0; i < LEN_X; i++) exp_x[i] = DW'(i * 5);
    for (int i = 0; i < LEN_F; i++) exp_f[i] = DW'(-i);
    stream("fresh", 100, 100, 1'b0, LEN_X, LEN_F);
    read_all("fresh_mem");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_input_loader.md
# conv_input_loader

Input stage of the conv_128_32 engine: receiver for the x and f valid/ready input streams. Accepts one 128-sample x vector and one 32-tap f vector in any interleaving, stores them in two local memories, then signals `loaded` and serves synchronous reads to the compute datapath. It accepts no further input until the datapath pulses `release`.

## Interface
- `LEN_X`, 128, x vector length (samples).
- `LEN_F`, 32, f vector length (taps).
- `DW`, 8, sample width, signed two's complement.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately, independent of `clk`.
- `s_data_in_x`  in  DW  x sample.
- `s_valid_x`  in  1  x sample valid.
- `s_ready_x`  out  1  loader can take an x sample.
- `s_data_in_f`  in  DW  f tap.
- `s_valid_f`  in  1  f tap valid.
- `s_ready_f`  out  1  loader can take an f tap.
- `loaded`  out  1  both vectors are complete and readable.
- `release`  in  1  single-cycle pulse from the datapath; frees the buffers.
- `rd_addr_x`  in  $clog2(LEN_X)  x read address.
- `rd_data_x`  out  DW  x read data.
- `rd_addr_f`  in  $clog2(LEN_F)  f read address.
- `rd_data_f`  out  DW  f read data.

## Operation
- States:
  - LOAD: accepting input.
  - FULL: holding a complete vector pair.
- Counters: `x_cnt` counts 0..LEN_X; `f_cnt` counts 0..LEN_F.
- LOAD behaviour:
  - `s_ready_x = (x_cnt != LEN_X)`.
  - `s_ready_f = (f_cnt != LEN_F)`.
  - The x and f channels are fully independent. Either may finish first. They may handshake in the same cycle.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
  - An x transfer writes `s_data_in_x` to x memory at address `x_cnt`, then increments `x_cnt`. The f channel works the same way.
  - `s_data_in_*` is ignored, and may be X, whenever valid is 0 or ready is 0.
- LOAD→FULL: on the edge where `x_cnt == LEN_X` and `f_cnt == LEN_F` are both true, counting any transfer on that same edge.
- FULL behaviour:
  - Both readys are 0 and `loaded` is 1.
  - Input valids are ignored.
  - Memory contents are frozen.
- FULL→LOAD: on an edge with `release == 1`. Both counters clear to 0 on that edge.
- `release` in LOAD is ignored. It has no effect on the counters or the memories.
- Reads: `rd_data_*` is registered and valid one cycle after `rd_addr_*` is presented. Reads are legal in any state; data is meaningful only in FULL.
- Reset (`reset == 0`):
  - State goes to LOAD and both counters to 0.
  - `loaded`, `s_ready_x`, `s_ready_f` go to 0 while reset is held. Both readys go to 1 on the first edge after reset deasserts.
  - `rd_data_x` and `rd_data_f` reset to 0.
  - Memory contents are not reset.
  - A reset in the middle of a load discards the partial vector.

## Timing
- Readys are decoded from registered state and counters only. They have no combinational path from any valid input.
- `loaded` rises in the cycle after the final completing transfer.
- `s_ready_x` / `s_ready_f` rise in the cycle after the `release` edge.
- Back-to-back throughput: one x and one f transfer per cycle.
  - Minimum load time is max(LEN_X, LEN_F) = 128 cycles.
  - `loaded` is high at cycle 129 after the first transfer.
- Read latency: 1 cycle, address to data.

## Structure
- Shared package `conv_pkg` holds:
  - constants `LEN_X`, `LEN_F`, `DW`;
  - the state typedef `loader_state_t` with values LOAD and FULL.
- Sub-module `loader_mem`: parameterized DEPTH×DW, one write port, one synchronous read port with registered output that resets to 0. It is instantiated once for x and once for f.
- The top level contains only the counters, the FSM and the ready/loaded decode.

## Test plan
- **Continuous streams**: x = -128..-1 and f = -64..-33 with valids held high → `s_ready_f` drops after 32 f transfers. `loaded` rises exactly 1 cycle after the 128th x transfer. Reading x[5] returns -123 and f[31] returns -33.
- **Randomized valids**: both valids randomized, with X driven on data while invalid → memory contents match the stream order exactly. No write occurs on any cycle where valid or ready is 0.
- **f finishes last**: send all x first, then f → `loaded` stays 0 until the 32nd f transfer and is 1 on the next cycle.
- **FULL and release**: hold valids high while FULL → no transfers, readys stay 0. Pulse `release` → readys are 1 on the next cycle. Load a second pair (x = 0..127, f = 0..31) → reading x[127] returns 127.
- **Release in LOAD**: pulse `release` after 10 x transfers → `x_cnt` is still 10 and the load completes normally.
- **Mid-load reset**: assert `reset` low asynchronously after 50 x transfers, off a clock edge → readys and `loaded` drop immediately. After deassertion a full fresh load of 128 x and 32 f is required before `loaded` rises.
